// File: rtl/clock_pkg.sv
// clock_pkg: shared FSM states, field limits and BCD helpers for the 24-hour clock
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
  typedef logic [3:0] digit_t;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  function automatic logic [7:0] pair_inc(input logic [7:0] v, input int max);
    logic [7:0] m;
    m = {4'(max / 10), 4'(max % 10)};
    return v == m ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter: two-digit BCD counter wrapping MAX->00 on inc, clr overriding inc
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59,
  parameter int TW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [TW-1:0] tens,
  output digit_t        units,
  output logic          at_max
);
  localparam logic [TW-1:0] MT = TW'(MAX / 10);
  localparam digit_t MU = digit_t'(MAX % 10);
  assign at_max = tens == MT && units == MU;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens  <= '0;
      units <= '0;
    end else if (clr || (inc && at_max)) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      units <= units == 4'd9 ? 4'd0 : units + 4'd1;
      tens  <= units == 4'd9 ? tens + TW'(1) : tens;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set FSM and enable-driven BCD timekeeper; ALARM_EN adds the alarm compare
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
`ifdef ALARM_EN
  input  logic       alarm_arm,
  input  logic [1:0] alarm_hr_tens,
  input  digit_t     alarm_hr_units,
  input  digit_t     alarm_min_tens,
  input  digit_t     alarm_min_units,
  output logic       alarm_pulse,
`endif
  output digit_t     sec_units,
  output digit_t     sec_tens,
  output digit_t     min_units,
  output digit_t     min_tens,
  output digit_t     hour_units,
  output logic [1:0] hour_tens,
  output logic       set_active,
  output logic       blink_hr,
  output logic       blink_min,
  output logic       day_wrap
);
  state_t state, state_nxt;
  logic [7:0] to_cnt, to_nxt;
  logic sec_inc, min_inc, hr_inc, sec_clr;
  logic sec_max, min_max, hr_max;
  logic run_tick, expire, dw_nxt;
  bcd_pair_counter #(.MAX(SEC_MAX), .TW(4)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .clr(sec_clr),
    .tens(sec_tens), .units(sec_units), .at_max(sec_max)
  );
  bcd_pair_counter #(.MAX(MIN_MAX), .TW(4)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .tens(min_tens), .units(min_units), .at_max(min_max)
  );
  bcd_pair_counter #(.MAX(HR_MAX), .TW(2)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
    .tens(hour_tens), .units(hour_units), .at_max(hr_max)
  );
  assign run_tick = state == RUN && tick_1hz && !mode_btn;
  assign expire   = tick_1hz && to_cnt == 8'(TIMEOUT_TICKS - 1);
  assign dw_nxt   = run_tick && sec_max && min_max && hr_max;
  always_comb begin
    state_nxt = state;
    to_nxt    = '0;
    sec_inc   = 1'b0;
    min_inc   = 1'b0;
    hr_inc    = 1'b0;
    sec_clr   = 1'b0;
    case (state)
      RUN: begin
        state_nxt = mode_btn ? SET_HR : RUN;
        sec_inc   = run_tick;
        min_inc   = run_tick && sec_max;
        hr_inc    = run_tick && sec_max && min_max;
      end
      SET_HR: begin
        state_nxt = mode_btn ? SET_MIN : (!inc_btn && expire) ? RUN : SET_HR;
        hr_inc    = !mode_btn && inc_btn;
        sec_clr   = !mode_btn && !inc_btn && expire;
        to_nxt    = (!mode_btn && !inc_btn && tick_1hz && !expire) ? to_cnt + 8'd1 : 8'd0;
      end
      SET_MIN: begin
        state_nxt = (mode_btn || (!inc_btn && expire)) ? RUN : SET_MIN;
        min_inc   = !mode_btn && inc_btn;
        sec_clr   = mode_btn || (!inc_btn && expire);
        to_nxt    = (!mode_btn && !inc_btn && tick_1hz && !expire) ? to_cnt + 8'd1 : 8'd0;
      end
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      to_cnt     <= '0;
      set_active <= 1'b0;
      blink_hr   <= 1'b0;
      blink_min  <= 1'b0;
      day_wrap   <= 1'b0;
    end else begin
      state      <= state_nxt;
      to_cnt     <= to_nxt;
      set_active <= state_nxt != RUN;
      blink_hr   <= state_nxt == SET_HR;
      blink_min  <= state_nxt == SET_MIN;
      day_wrap   <= dw_nxt;
    end
  end
`ifdef ALARM_EN
  logic [7:0] min_n, hr_n;
  logic al_nxt;
  assign min_n  = pair_inc({min_tens, min_units}, MIN_MAX);
  assign hr_n   = min_max ? pair_inc({2'b00, hour_tens, hour_units}, HR_MAX) : {2'b00, hour_tens, hour_units};
  assign al_nxt = run_tick && sec_max && alarm_arm && min_n == {alarm_min_tens, alarm_min_units} &&
                  hr_n == {2'b00, alarm_hr_tens, alarm_hr_units};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alarm_pulse <= 1'b0;
    else alarm_pulse <= al_nxt;
  end
`endif
endmodule
